// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - MIPS register file with write-through bypass and debug read port
// Register 0 reads as zero everywhere; writes to it are discarded and uncounted.
module reg_file_bypass #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rd_addr1,
  input  logic [ADDR_BITS-1:0] rd_addr2,
  output logic [WIDTH-1:0]     rd_data1,
  output logic [WIDTH-1:0]     rd_data2,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]     dbg_data,
  output logic [15:0]          wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_hit;

  // wr_en is tested first so an undriven wr_addr cannot produce a write.
  assign wr_hit = wr_en && !reset && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
      wr_count      <= wr_count + 16'd1;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 :
                    (wr_hit && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 :
                    (wr_hit && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
  assign dbg_data = (dbg_addr == '0) ? '0 :
                    (wr_hit && wr_addr == dbg_addr) ? wr_data : regs[dbg_addr];

endmodule
